dphy_byte_align: RTL and testbench

- Sits directly downstream of the per-lane D-PHY HS deserializer in the CSI-2 receiver.
- Consumes the free-running, unaligned 8-bit words from the ISERDES, one per byte clock.
- Searches the HS leader for the sync byte and locks a bit offset (0..7).
- Emits byte-aligned payload with a valid flag to the lane merger / packet parser.

---
 rtl/dphy_byte_align.sv | 118 +++++++++++
 tb/tb_dphy_byte_align.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dphy_byte_align.sv
// D-PHY HS byte aligner: finds the sync byte in the raw deserializer stream and emits aligned bytes.
// Optional: define DPHY_ALIGN_1BIT_ERR_EN to also lock on a sync byte with one flipped bit.
module dphy_byte_align #(
  parameter logic [7:0] SYNC_BYTE    = 8'hB8,
  parameter int         SYNC_TIMEOUT = 32
) (
  input  logic       byte_clk_i,
  input  logic       rst_i,
  input  logic       hs_active_i,
  input  logic [7:0] unaligned_byte_i,
  output logic [7:0] aligned_byte_o,
  output logic       aligned_valid_o,
  output logic       sync_found_o,
  output logic       sync_err_o,
  output logic [2:0] bit_offset_o
);

  localparam int CW = $clog2(SYNC_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    ALIGNED,
    WAIT_LP
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [7:0]    prev;
  logic [15:0]   window;
  logic          hit;
  logic [2:0]    hit_k;
  logic          lock;
  logic          tout;
  logic          emit;

  assign window = {unaligned_byte_i, prev};
  assign emit   = hs_active_i && (state == ALIGNED);

  // Scan high to low so the lowest matching offset is the one kept.
  always_comb begin
    hit   = 1'b0;
    hit_k = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (window[k +: 8] == SYNC_BYTE) begin
        hit   = 1'b1;
        hit_k = 3'(k);
      end
    end
`ifdef DPHY_ALIGN_1BIT_ERR_EN
    if (!hit) begin
      for (int k = 7; k >= 0; k--) begin
        if ($countones(window[k +: 8] ^ SYNC_BYTE) <= 1) begin
          hit   = 1'b1;
          hit_k = 3'(k);
        end
      end
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lock      = 1'b0;
    tout      = 1'b0;
    if (!hs_active_i) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          state_nxt = SEARCH;
          cnt_nxt   = '0;
        end
        SEARCH: begin
          if (hit) begin
            state_nxt = ALIGNED;
            lock      = 1'b1;
          end else if (cnt == CW'(SYNC_TIMEOUT - 1)) begin
            state_nxt = WAIT_LP;
            tout      = 1'b1;
          end else if (cnt != '1) begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        ALIGNED: state_nxt = ALIGNED;
        WAIT_LP: state_nxt = WAIT_LP;
      endcase
    end
  end

  always_ff @(posedge byte_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state           <= IDLE;
      cnt             <= '0;
      prev            <= 8'h00;
      aligned_byte_o  <= 8'h00;
      aligned_valid_o <= 1'b0;
      sync_found_o    <= 1'b0;
      sync_err_o      <= 1'b0;
      bit_offset_o    <= 3'd0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      prev            <= unaligned_byte_i;
      sync_found_o    <= lock;
      sync_err_o      <= tout;
      aligned_valid_o <= emit;
      if (lock) begin
        bit_offset_o <= hit_k;
      end
      if (emit) begin
        aligned_byte_o <= window[bit_offset_o +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dphy_byte_align.sv
// Directed bench for dphy_byte_align: per-cycle vector table plus burst sequences.
module tb_dphy_byte_align;

  logic       clk = 1'b0;
  logic       rst;
  logic       hs;
  logic [7:0] din;
  logic [7:0] dout;
  logic       vld;
  logic       fnd;
  logic       err;
  logic [2:0] off;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] stim[$];
  logic [7:0] vq[$];
  int         found_n;
  int         err_n;
  int         err_at;
  logic [2:0] found_off;

  typedef struct {
    logic       hs;
    logic [7:0] din;
    logic       vld;
    logic [7:0] dout;
    logic       fnd;
    logic       err;
    logic [2:0] off;
  } vec_t;

  vec_t tbl[9];

  dphy_byte_align dut (
    .byte_clk_i      (clk),
    .rst_i           (rst),
    .hs_active_i     (hs),
    .unaligned_byte_i(din),
    .aligned_byte_o  (dout),
    .aligned_valid_o (vld),
    .sync_found_o    (fnd),
    .sync_err_o      (err),
    .bit_offset_o    (off)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic sample(input int idx);
    if (fnd) begin
      found_n++;
      found_off = off;
    end
    if (err) begin
      err_n++;
      err_at = idx;
    end
    if (vld) vq.push_back(dout);
  endtask

  // Drives stim with hs high, then a few idle cycles with hs low.
  task automatic run_burst();
    found_n   = 0;
    err_n     = 0;
    err_at    = -1;
    found_off = 3'd0;
    vq.delete();
    for (int i = 0; i < stim.size(); i++) begin
      hs  = 1'b1;
      din = stim[i];
      @(negedge clk);
      sample(i);
    end
    for (int i = 0; i < 3; i++) begin
      hs  = 1'b0;
      din = 8'h00;
      @(negedge clk);
      sample(stim.size() + i);
    end
  endtask

  task automatic load_shifted(input logic [95:0] pat, input int sh);
    logic [95:0] s;
    s = pat << sh;
    stim.delete();
    for (int j = 0; j < 12; j++) stim.push_back(s[8*j +: 8]);
  endtask

  task automatic load_zeros_then(input int nz, input logic [7:0] a,
                                 input logic [7:0] b, input logic [7:0] c);
    stim.delete();
    for (int j = 0; j < nz; j++) stim.push_back(8'h00);
    stim.push_back(a);
    stim.push_back(b);
    stim.push_back(c);
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0};
    tbl[1] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0};
    tbl[2] = '{1'b1, 8'hB8, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0};
    tbl[3] = '{1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0};
    tbl[4] = '{1'b1, 8'h22, 1'b1, 8'h11, 1'b0, 1'b0, 3'd0};
    tbl[5] = '{1'b1, 8'h33, 1'b1, 8'h22, 1'b0, 1'b0, 3'd0};
    tbl[6] = '{1'b1, 8'h44, 1'b1, 8'h33, 1'b0, 1'b0, 3'd0};
    tbl[7] = '{1'b0, 8'h55, 1'b0, 8'h33, 1'b0, 1'b0, 3'd0};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 8'h33, 1'b0, 1'b0, 3'd0};

    rst = 1'b1;
    hs  = 1'b0;
    din = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {19'd0, vld, fnd, err, off, dout}, 32'd0);
    rst = 1'b0;

    // Offset 0, per-cycle table including the burst drop mid-payload.
    for (int i = 0; i < 9; i++) begin
      hs  = tbl[i].hs;
      din = tbl[i].din;
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), {31'd0, vld}, {31'd0, tbl[i].vld});
      chk($sformatf("tbl%0d_byte", i), {24'd0, dout}, {24'd0, tbl[i].dout});
      chk($sformatf("tbl%0d_found", i), {31'd0, fnd}, {31'd0, tbl[i].fnd});
      chk($sformatf("tbl%0d_err", i), {31'd0, err}, {31'd0, tbl[i].err});
      chk($sformatf("tbl%0d_off", i), {29'd0, off}, {29'd0, tbl[i].off});
    end

    // Offset 5: B8,A5,3C serialised after 21 zero bits.
    load_shifted(96'h3CA5B8, 21);
    run_burst();
    chk("off5_found_cnt", found_n, 1);
    chk("off5_offset", {29'd0, found_off}, 32'd5);
    chk("off5_err_cnt", err_n, 0);
    chk("off5_nvalid_ge2", {31'd0, vq.size() >= 2}, 32'd1);
    chk("off5_byte0", {24'd0, vq.size() > 0 ? vq[0] : 8'hxx}, 32'hA5);
    chk("off5_byte1", {24'd0, vq.size() > 1 ? vq[1] : 8'hxx}, 32'h3C);

    // Timeout, then a late sync in the same burst must be ignored.
    load_zeros_then(40, 8'hB8, 8'h11, 8'h22);
    run_burst();
    chk("tout_err_cnt", err_n, 1);
    chk("tout_err_cycle", err_at, 32);
    chk("tout_found_cnt", found_n, 0);
    chk("tout_nvalid", vq.size(), 0);

    // Match on the last search cycle locks instead of erroring.
    load_zeros_then(31, 8'hB8, 8'h11, 8'h22);
    run_burst();
    chk("edge_found_cnt", found_n, 1);
    chk("edge_err_cnt", err_n, 0);
    chk("edge_byte0", {24'd0, vq.size() > 0 ? vq[0] : 8'hxx}, 32'h11);

    // One cycle too late: timeout wins.
    load_zeros_then(32, 8'hB8, 8'h11, 8'h22);
    run_burst();
    chk("late_found_cnt", found_n, 0);
    chk("late_err_cycle", err_at, 32);

    // Relock at offset 2.
    load_shifted(96'hC35AB8, 18);
    run_burst();
    chk("off2_found_cnt", found_n, 1);
    chk("off2_offset", {29'd0, found_off}, 32'd2);
    chk("off2_byte0", {24'd0, vq.size() > 0 ? vq[0] : 8'hxx}, 32'h5A);
    chk("off2_byte1", {24'd0, vq.size() > 1 ? vq[1] : 8'hxx}, 32'hC3);

    // Async reset while aligned.
    stim.delete();
    stim.push_back(8'h00);
    stim.push_back(8'h00);
    stim.push_back(8'hB8);
    stim.push_back(8'h11);
    stim.push_back(8'h22);
    stim.push_back(8'h33);
    for (int i = 0; i < stim.size(); i++) begin
      hs  = 1'b1;
      din = stim[i];
      @(negedge clk);
    end
    chk("pre_rst_valid", {31'd0, vld}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outputs", {19'd0, vld, fnd, err, off, dout}, 32'd0);
    @(negedge clk);
    hs  = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din = (i == 1) ? 8'hB8 : 8'h11;
      @(negedge clk);
      chk($sformatf("post_rst_idle%0d", i), {30'd0, vld, fnd}, 32'd0);
    end
    stim.delete();
    stim.push_back(8'h00);
    stim.push_back(8'h00);
    stim.push_back(8'hB8);
    stim.push_back(8'h11);
    stim.push_back(8'h22);
    run_burst();
    chk("rst_relock_found", found_n, 1);
    chk("rst_relock_byte0", {24'd0, vq.size() > 0 ? vq[0] : 8'hxx}, 32'h11);

    // Corrupted sync byte B9 at offset 0.
    load_zeros_then(2, 8'hB9, 8'h11, 8'h22);
    for (int j = 0; j < 36; j++) stim.push_back(8'h00);
    run_burst();
`ifdef DPHY_ALIGN_1BIT_ERR_EN
    chk("tol_found_cnt", found_n, 1);
    chk("tol_offset", {29'd0, found_off}, 32'd0);
    chk("tol_err_cnt", err_n, 0);
    chk("tol_byte0", {24'd0, vq.size() > 0 ? vq[0] : 8'hxx}, 32'h11);
`else
    chk("tol_found_cnt", found_n, 0);
    chk("tol_err_cnt", err_n, 1);
    chk("tol_err_cycle", err_at, 32);
    chk("tol_nvalid", vq.size(), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
